// File: rtl/fp_divider_iter.sv
// fp_divider_iter
// Sequential floating-point divider: quotient = a / b.
// The mantissa quotient is built by radix-2 restoring division, one bit
// per clock, then rounded to nearest-even. Special operands (NaN, inf,
// zero) bypass the divide loop and complete one edge after acceptance.
// Subnormal operands are treated as zero, and tiny results flush to zero.
//
// Handshake semantics (both ports):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. The producer holds valid and its data stable until that edge.
//   in_ready is high only in IDLE (also while rst is asserted). out_valid
//   is high only in DONE, and result/flags stay constant until out_ready
//   completes the transfer. out_ready is ignored in every other state.
//
// dbg_state exposes the FSM state so that checkers can bind to it:
//   0 = IDLE, 1 = DIVIDE, 2 = ROUND, 3 = DONE.

module fp_divider_iter #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [4:0]   flags,
  output logic [1:0]   dbg_state
);

  // Derived constants
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int NQ    = MAN_W + 3;
  localparam int EW2   = EXP_W + 2;
  localparam int CNT_W = $clog2(NQ + 1);

  localparam logic signed [EW2-1:0] EXP_BIAS = EW2'(BIAS);
  localparam logic signed [EW2-1:0] EXP_MAX  = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] EXP_ONE  = EW2'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(NQ - 1);

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Flag bit positions: {invalid, div_by_zero, overflow, underflow, inexact}
  localparam logic [4:0] FL_INVALID = 5'b10000;
  localparam logic [4:0] FL_DBZ     = 5'b01000;
  localparam logic [4:0] FL_OVF     = 5'b00101;
  localparam logic [4:0] FL_UNF     = 5'b00011;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_ROUND  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_t                  r_state;
  logic                    r_sign;
  logic signed [EW2-1:0]   r_exp;
  logic [MAN_W+1:0]        r_rem;
  logic [MAN_W:0]          r_mb;
  logic [NQ-1:0]           r_q;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_out_valid;
  logic [W-1:0]            r_result;
  logic [4:0]              r_flags;

  // ---------------------------------------------------------------------
  // Operand decode (looked at only while IDLE)
  // ---------------------------------------------------------------------
  logic [EXP_W-1:0]        w_ea;
  logic [EXP_W-1:0]        w_eb;
  logic [MAN_W-1:0]        w_fa;
  logic [MAN_W-1:0]        w_fb;
  logic                    w_sign;
  logic                    w_a_zero;
  logic                    w_b_zero;
  logic                    w_a_inf;
  logic                    w_b_inf;
  logic                    w_a_nan;
  logic                    w_b_nan;
  logic signed [EW2-1:0]   w_exp_init;

  assign w_ea   = a[W-2:MAN_W];
  assign w_eb   = b[W-2:MAN_W];
  assign w_fa   = a[MAN_W-1:0];
  assign w_fb   = b[MAN_W-1:0];
  assign w_sign = a[W-1] ^ b[W-1];

  // exp = 0 covers both true zero and flushed subnormals
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_nan  = (&w_ea) & (|w_fa);
  assign w_b_nan  = (&w_eb) & (|w_fb);
  assign w_a_inf  = (&w_ea) & ~(|w_fa);
  assign w_b_inf  = (&w_eb) & ~(|w_fb);

  // Biased quotient exponent in a signed field wide enough for both extremes
  assign w_exp_init = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + EXP_BIAS;

  logic                    w_special;
  logic [W-1:0]            w_spec_res;
  logic [4:0]              w_spec_flags;

  // Special-case result selection; priority order matters (NaN rules first)
  always_comb begin
    w_special    = 1'b1;
    w_spec_res   = '0;
    w_spec_flags = '0;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec_res   = QNAN;
      w_spec_flags = FL_INVALID;
    end else if (w_a_inf) begin
      w_spec_res   = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_b_zero) begin
      w_spec_res   = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_spec_flags = FL_DBZ;
    end else if (w_a_zero || w_b_inf) begin
      w_spec_res   = {w_sign, {(W-1){1'b0}}};
    end else begin
      w_special    = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // One restoring-division step
  // ---------------------------------------------------------------------
  logic                    w_ge;
  logic [MAN_W+1:0]        w_rem_sub;
  logic [MAN_W+1:0]        w_rem_next;

  // The remainder stays below 2*mb, so the shifted value always fits
  assign w_ge       = (r_rem >= {1'b0, r_mb});
  assign w_rem_sub  = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
  assign w_rem_next = w_rem_sub << 1;

  // ---------------------------------------------------------------------
  // Normalise, round and range check (used in ROUND)
  // ---------------------------------------------------------------------
  logic                    w_rem_nz;
  logic [MAN_W-1:0]        w_frac_pre;
  logic                    w_guard;
  logic                    w_sticky;
  logic signed [EW2-1:0]   w_exp_n;
  logic                    w_inc;
  logic [MAN_W:0]          w_frac_rnd;
  logic signed [EW2-1:0]   w_exp_r;
  logic                    w_inexact;
  logic [W-1:0]            w_rnd_res;
  logic [4:0]              w_rnd_flags;

  assign w_rem_nz = |r_rem;

  // Q[NQ-1] tells whether ma/mb landed in [1,2) or [0.5,1); the hidden bit
  // is dropped here, only the stored fraction goes through the rounder
  always_comb begin
    if (r_q[NQ-1]) begin
      w_frac_pre = r_q[NQ-2:2];
      w_guard    = r_q[1];
      w_sticky   = r_q[0] | w_rem_nz;
      w_exp_n    = r_exp;
    end else begin
      w_frac_pre = r_q[NQ-3:1];
      w_guard    = r_q[0];
      w_sticky   = w_rem_nz;
      w_exp_n    = r_exp - EXP_ONE;
    end
  end

  // Ties-to-even increment; a carry out of the fraction bumps the exponent
  // and leaves the fraction bits at zero
  assign w_inc      = w_guard & (w_sticky | w_frac_pre[0]);
  assign w_frac_rnd = {1'b0, w_frac_pre} + {{MAN_W{1'b0}}, w_inc};
  assign w_exp_r    = w_frac_rnd[MAN_W] ? (w_exp_n + EXP_ONE) : w_exp_n;
  assign w_inexact  = w_guard | w_sticky;

  // Overflow to infinity, flush-to-zero on underflow, else pack
  always_comb begin
    w_rnd_res   = {r_sign, w_exp_r[EXP_W-1:0], w_frac_rnd[MAN_W-1:0]};
    w_rnd_flags = {4'b0000, w_inexact};
    if (w_exp_r >= EXP_MAX) begin
      w_rnd_res   = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_rnd_flags = FL_OVF;
    end else if (w_exp_r[EW2-1] || (w_exp_r == '0)) begin
      w_rnd_res   = {r_sign, {(W-1){1'b0}}};
      w_rnd_flags = FL_UNF;
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------
  // Sequences accept -> divide -> round -> hold result until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_rem       <= '0;
      r_mb        <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign  <= w_sign;
            r_flags <= '0;
            if (w_special) begin
              r_result    <= w_spec_res;
              r_flags     <= w_spec_flags;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_rem   <= {1'b0, 1'b1, w_fa};
              r_mb    <= {1'b1, w_fb};
              r_exp   <= w_exp_init;
              r_q     <= '0;
              r_cnt   <= '0;
              r_state <= S_DIVIDE;
            end
          end
        end
        S_DIVIDE: begin
          r_rem <= w_rem_next;
          r_q   <= {r_q[NQ-2:0], w_ge};
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_result    <= w_rnd_res;
          r_flags     <= w_rnd_flags;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;
  assign dbg_state = r_state;

endmodule
